// File: rtl/izh_pkg.sv
// Shared definitions for the Izhikevich neuron system and its spike monitor.
package izh_pkg;

    localparam int unsigned MEMBRANE_W    = 8;
    localparam int unsigned DEF_WINDOW_W  = 16;
    localparam int unsigned DEF_COUNT_W   = 8;
    localparam int unsigned DEF_ISI_W     = 12;

    typedef logic [1:0] mon_state_t;

    localparam mon_state_t MON_IDLE    = 2'd0;
    localparam mon_state_t MON_MEASURE = 2'd1;
    localparam mon_state_t MON_REPORT  = 2'd2;

endpackage

// File: rtl/izh_isi_timer.sv
// Edge-triggered saturating inter-spike interval timer; exposes next-state values so the
// parent can capture a final sample in the same cycle it happens.
module izh_isi_timer #(
    parameter int unsigned ISI_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             tick,
    input  logic             spike_edge,
    output logic [ISI_W-1:0] isi_next,
    output logic             ovf_next
);

    localparam logic [ISI_W-1:0] ISI_MAX = '1;

    logic [ISI_W-1:0] tmr_q, tmr_d;
    logic [ISI_W-1:0] work_q, work_d;
    logic             seen_q, seen_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        tmr_d  = tmr_q;
        work_d = work_q;
        seen_d = seen_q;
        ovf_d  = ovf_q;
        if (clear) begin
            tmr_d  = '0;
            work_d = '0;
            seen_d = 1'b0;
            ovf_d  = 1'b0;
        end else if (tick) begin
            if (spike_edge) begin
                // Interval only exists once an earlier edge was seen in this window.
                if (seen_q) begin
                    if (tmr_q == ISI_MAX) begin
                        work_d = ISI_MAX;
                        ovf_d  = 1'b1;
                    end else begin
                        work_d = tmr_q + 1'b1;
                    end
                end
                tmr_d  = '0;
                seen_d = 1'b1;
            end else if (seen_q) begin
                if (tmr_q == ISI_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_q  <= '0;
            work_q <= '0;
            seen_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            tmr_q  <= tmr_d;
            work_q <= work_d;
            seen_q <= seen_d;
            ovf_q  <= ovf_d;
        end
    end

    assign isi_next = work_d;
    assign ovf_next = ovf_d;

endmodule

// File: rtl/izh_spike_monitor.sv
// Windowed spike monitor: counts rising edges, tracks last ISI and peak membrane over N
// enabled cycles, then presents the result through a valid/ack register.
module izh_spike_monitor
    import izh_pkg::*;
#(
    parameter int unsigned WINDOW_W = DEF_WINDOW_W,
    parameter int unsigned COUNT_W  = DEF_COUNT_W,
    parameter int unsigned ISI_W    = DEF_ISI_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  spike_in,
    input  logic [MEMBRANE_W-1:0] membrane_in,
    input  logic [WINDOW_W-1:0]   window_len,
    input  logic                  start,
    input  logic                  result_ack,
    output logic                  busy,
    output logic                  result_valid,
    output logic [COUNT_W-1:0]    spike_count,
    output logic [ISI_W-1:0]      isi_last,
    output logic [MEMBRANE_W-1:0] peak_membrane,
    output logic                  overflow
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    mon_state_t state_q, state_d;

    logic [WINDOW_W-1:0]   win_cnt_q, win_cnt_d;
    logic [COUNT_W-1:0]    cnt_q, cnt_d;
    logic [MEMBRANE_W-1:0] peak_q, peak_d;
    logic                  cnt_ovf_q, cnt_ovf_d;
    logic                  spike_d_q, spike_d_d;

    logic [COUNT_W-1:0]    spike_count_q;
    logic [ISI_W-1:0]      isi_last_q;
    logic [MEMBRANE_W-1:0] peak_membrane_q;
    logic                  overflow_q;

    logic             tick, spike_edge, start_ok, accept, last_sample;
    logic [ISI_W-1:0] isi_next;
    logic             isi_ovf_next;

    assign tick        = (state_q == MON_MEASURE) && enable;
    assign spike_edge  = tick && spike_in && !spike_d_q;
    assign start_ok    = start && (window_len != '0);
    assign accept      = start_ok && ((state_q == MON_IDLE) ||
                                      ((state_q == MON_REPORT) && result_ack));
    assign last_sample = tick && (win_cnt_q == WINDOW_W'(1));

    izh_isi_timer #(
        .ISI_W(ISI_W)
    ) u_isi_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (accept),
        .tick      (tick),
        .spike_edge(spike_edge),
        .isi_next  (isi_next),
        .ovf_next  (isi_ovf_next)
    );

    always_comb begin
        win_cnt_d = win_cnt_q;
        cnt_d     = cnt_q;
        peak_d    = peak_q;
        cnt_ovf_d = cnt_ovf_q;
        spike_d_d = spike_d_q;
        if (accept) begin
            win_cnt_d = window_len;
            cnt_d     = '0;
            peak_d    = '0;
            cnt_ovf_d = 1'b0;
            spike_d_d = 1'b0;
        end else if (tick) begin
            win_cnt_d = win_cnt_q - 1'b1;
            spike_d_d = spike_in;
            if (membrane_in > peak_q) begin
                peak_d = membrane_in;
            end
            if (spike_edge) begin
                if (cnt_q == COUNT_MAX) begin
                    cnt_ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MON_IDLE:    if (accept) state_d = MON_MEASURE;
            MON_MEASURE: if (last_sample) state_d = MON_REPORT;
            MON_REPORT:  if (result_ack) state_d = accept ? MON_MEASURE : MON_IDLE;
            default:     state_d = MON_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= MON_IDLE;
            win_cnt_q       <= '0;
            cnt_q           <= '0;
            peak_q          <= '0;
            cnt_ovf_q       <= 1'b0;
            spike_d_q       <= 1'b0;
            spike_count_q   <= '0;
            isi_last_q      <= '0;
            peak_membrane_q <= '0;
            overflow_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            cnt_q     <= cnt_d;
            peak_q    <= peak_d;
            cnt_ovf_q <= cnt_ovf_d;
            spike_d_q <= spike_d_d;
            // Final sample's edge and peak are folded in via the next-state values.
            if (last_sample) begin
                spike_count_q   <= cnt_d;
                isi_last_q      <= isi_next;
                peak_membrane_q <= peak_d;
                overflow_q      <= cnt_ovf_d || isi_ovf_next;
            end
        end
    end

    assign busy          = (state_q == MON_MEASURE);
    assign result_valid  = (state_q == MON_REPORT);
    assign spike_count   = spike_count_q;
    assign isi_last      = isi_last_q;
    assign peak_membrane = peak_membrane_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_izh_spike_monitor.sv
// Directed self-checking bench for izh_spike_monitor.
module tb_izh_spike_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        spike_in;
    logic [7:0]  membrane_in;
    logic [15:0] window_len;
    logic        start;
    logic        result_ack;
    logic        busy;
    logic        result_valid;
    logic [7:0]  spike_count;
    logic [11:0] isi_last;
    logic [7:0]  peak_membrane;
    logic        overflow;

    int tests = 0;
    int failed = 0;

    izh_spike_monitor #(
        .WINDOW_W(16),
        .COUNT_W (8),
        .ISI_W   (12)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .spike_in     (spike_in),
        .membrane_in  (membrane_in),
        .window_len   (window_len),
        .start        (start),
        .result_ack   (result_ack),
        .busy         (busy),
        .result_valid (result_valid),
        .spike_count  (spike_count),
        .isi_last     (isi_last),
        .peak_membrane(peak_membrane),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic begin_window(input logic [15:0] len);
        window_len = len;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    task automatic ack();
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; spike_in = 1'b0; membrane_in = '0;
        window_len = '0; start = 1'b0; result_ack = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(result_valid), 0);
        check("rst_count", 32'(spike_count), 0);
        check("rst_isi", 32'(isi_last), 0);
        check("rst_peak", 32'(peak_membrane), 0);
        check("rst_ovf", 32'(overflow), 0);

        // 1: two pulses at enabled cycles 2 and 7 in a 10-cycle window
        begin_window(16'd10);
        check("t1_busy", 32'(busy), 1);
        for (int i = 1; i <= 10; i++) begin
            enable = 1'b1;
            spike_in = (i == 2) || (i == 7);
            membrane_in = 8'(i * 3);
            step();
            if (i == 9) check("t1_valid_early", 32'(result_valid), 0);
        end
        check("t1_valid", 32'(result_valid), 1);
        check("t1_busy_off", 32'(busy), 0);
        check("t1_count", 32'(spike_count), 2);
        check("t1_isi", 32'(isi_last), 5);
        check("t1_ovf", 32'(overflow), 0);
        check("t1_peak", 32'(peak_membrane), 30);
        enable = 1'b0; spike_in = 1'b0;
        step();
        step();
        check("t1_valid_hold", 32'(result_valid), 1);
        ack();
        check("t1_valid_drop", 32'(result_valid), 0);
        check("t1_count_kept", 32'(spike_count), 2);

        // 2: spike held high for 4 cycles counts once
        begin_window(16'd8);
        for (int i = 1; i <= 8; i++) begin
            enable = 1'b1;
            spike_in = (i <= 4);
            membrane_in = 8'd5;
            step();
        end
        check("t2_valid", 32'(result_valid), 1);
        check("t2_count", 32'(spike_count), 1);
        check("t2_isi", 32'(isi_last), 0);
        ack();

        // 3: enable toggling; disabled cycles contribute nothing
        begin_window(16'd5);
        for (int k = 1; k <= 9; k++) begin
            enable = (k % 2) == 1;
            spike_in = (k == 3) || (k == 6);
            membrane_in = enable ? 8'd7 : 8'd250;
            step();
            if (k == 8) check("t3_valid_early", 32'(result_valid), 0);
        end
        enable = 1'b0; spike_in = 1'b0;
        check("t3_valid", 32'(result_valid), 1);
        check("t3_count", 32'(spike_count), 1);
        check("t3_peak", 32'(peak_membrane), 7);
        ack();

        // 4: 300 edges saturate the 8-bit counter
        begin_window(16'd600);
        for (int i = 1; i <= 600; i++) begin
            enable = 1'b1;
            spike_in = (i % 2) == 1;
            membrane_in = 8'd0;
            step();
        end
        spike_in = 1'b0;
        check("t4_count", 32'(spike_count), 255);
        check("t4_ovf", 32'(overflow), 1);
        check("t4_isi", 32'(isi_last), 2);
        ack();

        // ISI timer saturation after a single edge
        begin_window(16'd4200);
        for (int i = 1; i <= 4200; i++) begin
            enable = 1'b1;
            spike_in = (i == 1);
            step();
        end
        spike_in = 1'b0;
        check("tisi_count", 32'(spike_count), 1);
        check("tisi_isi", 32'(isi_last), 0);
        check("tisi_ovf", 32'(overflow), 1);
        ack();

        // 5: peak tracking, then back-to-back restart on ack
        begin_window(16'd3);
        for (int i = 1; i <= 3; i++) begin
            enable = 1'b1;
            membrane_in = (i == 1) ? 8'd10 : (i == 2) ? 8'd200 : 8'd50;
            step();
        end
        check("t5_peak", 32'(peak_membrane), 200);
        check("t5_count", 32'(spike_count), 0);
        check("t5_ovf", 32'(overflow), 0);
        result_ack = 1'b1; start = 1'b1; window_len = 16'd4;
        step();
        result_ack = 1'b0; start = 1'b0;
        check("t5_b2b_busy", 32'(busy), 1);
        check("t5_b2b_valid", 32'(result_valid), 0);
        check("t5_peak_kept", 32'(peak_membrane), 200);

        // 6: reset mid-measure, then zero-length start is ignored
        enable = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; enable = 1'b0;
        check("t6_busy", 32'(busy), 0);
        check("t6_valid", 32'(result_valid), 0);
        check("t6_peak", 32'(peak_membrane), 0);
        check("t6_ovf", 32'(overflow), 0);
        begin_window(16'd0);
        check("t6_zero_busy", 32'(busy), 0);
        step();
        check("t6_zero_busy2", 32'(busy), 0);
        check("t6_zero_valid", 32'(result_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
